// File: rtl/video_scanout.sv
// VGA scanout: dot-rate timing generator, 2-entry pixel prefetch FIFO and 2x2 pixel doubling
// from a 320x240 framebuffer served by the memory manager.
module video_scanout #(
    parameter int          H_ACTIVE       = 640,
    parameter int          H_FRONT        = 16,
    parameter int          H_SYNC         = 96,
    parameter int          H_BACK         = 48,
    parameter int          V_ACTIVE       = 480,
    parameter int          V_FRONT        = 10,
    parameter int          V_SYNC         = 2,
    parameter int          V_BACK         = 33,
    parameter int          CLOCKS_PER_DOT = 4,
    parameter logic [7:0]  UNDERRUN_COLOR = 8'hE0
) (
    input  logic       clock,
    input  logic       reset,
    output logic [8:0] videoXCoord,
    output logic [7:0] videoYCoord,
    input  logic [7:0] videoData,
    input  logic       videoDataReady,
    input  logic       clearUnderrun,
    output logic [7:0] pixelColor,
    output logic       hSync,
    output logic       vSync,
    output logic       displayActive,
    output logic       frameStart,
    output logic       underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLOCKS_PER_DOT > 1) ? $clog2(CLOCKS_PER_DOT) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLOCKS_PER_DOT - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [8:0]    X_LAST    = 9'(H_ACTIVE / 2 - 1);

    logic [DW-1:0] divider;
    logic [HW-1:0] hCount;
    logic [VW-1:0] vCount;

    logic [1:0][7:0] fifoMem;
    logic            rdPtr;
    logic            wrPtr;
    logic [1:0]      fifoCount;
    logic            dropNext;

    logic          dotTick;
    logic          activeNow;
    logic          popReq;
    logic          popDo;
    logic          pushDo;
    logic          flush;
    logic          fifoEmpty;
    logic          fifoFull;
    logic [VW-1:0] nextLine;
    logic [7:0]    nextY;

    assign dotTick   = (divider == DIV_LAST);
    assign activeNow = (hCount < H_ACT) && (vCount < V_ACT);
    assign fifoEmpty = (fifoCount == 2'd0);
    assign fifoFull  = (fifoCount == 2'd2);

    // Each framebuffer pixel covers two dots, so only even visible dots consume an entry.
    assign popReq = dotTick && activeNow && !hCount[0];
    assign popDo  = popReq && !fifoEmpty;
    assign flush  = dotTick && (hCount == H_ACT);

    // The first return after a coordinate jump belongs to the old request and is thrown away.
    assign pushDo = videoDataReady && !flush && !dropNext && (!fifoFull || popDo);

    assign nextLine = (vCount == V_LAST) ? '0 : vCount + 1'b1;
    assign nextY    = (nextLine < V_ACT) ? 8'(nextLine >> 1) : 8'd0;

    // Dot-rate timing counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divider <= '0;
            hCount  <= '0;
            vCount  <= '0;
        end else if (dotTick) begin
            divider <= '0;
            if (hCount == H_LAST) begin
                hCount <= '0;
                vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
            end else begin
                hCount <= hCount + 1'b1;
            end
        end else begin
            divider <= divider + 1'b1;
        end
    end

    // Registered display outputs, all derived from the counts before they advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixelColor    <= 8'd0;
            hSync         <= 1'b1;
            vSync         <= 1'b1;
            displayActive <= 1'b0;
            frameStart    <= 1'b0;
        end else begin
            frameStart <= dotTick && (hCount == '0) && (vCount == '0);
            if (dotTick) begin
                displayActive <= activeNow;
                hSync         <= !((hCount >= HS_START) && (hCount < HS_END));
                vSync         <= !((vCount >= VS_START) && (vCount < VS_END));
                if (!activeNow)
                    pixelColor <= 8'd0;
                else if (!hCount[0])
                    pixelColor <= fifoEmpty ? UNDERRUN_COLOR : fifoMem[rdPtr];
            end
        end
    end

    // Prefetch FIFO and fetch coordinates
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifoMem     <= '0;
            rdPtr       <= 1'b0;
            wrPtr       <= 1'b0;
            fifoCount   <= 2'd0;
            dropNext    <= 1'b1;
            videoXCoord <= 9'd0;
            videoYCoord <= 8'd0;
        end else if (flush) begin
            rdPtr       <= 1'b0;
            wrPtr       <= 1'b0;
            fifoCount   <= 2'd0;
            dropNext    <= 1'b1;
            videoXCoord <= 9'd0;
            videoYCoord <= nextY;
        end else begin
            if (videoDataReady && dropNext)
                dropNext <= 1'b0;
            if (pushDo) begin
                fifoMem[wrPtr] <= videoData;
                wrPtr          <= ~wrPtr;
                if (videoXCoord != X_LAST)
                    videoXCoord <= videoXCoord + 9'd1;
            end
            if (popDo)
                rdPtr <= ~rdPtr;
            unique case ({pushDo, popDo})
                2'b10:   fifoCount <= fifoCount + 2'd1;
                2'b01:   fifoCount <= fifoCount - 2'd1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // Sticky underrun; a fresh underrun outranks a simultaneous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            underrun <= 1'b0;
        else if (popReq && fifoEmpty)
            underrun <= 1'b1;
        else if (clearUnderrun)
            underrun <= 1'b0;
    end

endmodule

// File: tb/tb_video_scanout.sv
// Directed bench for video_scanout on a reduced 24x12-dot raster so several frames fit in a short run.
module tb_video_scanout;

    localparam int HA = 16, HF = 2, HS = 4, HB = 2;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int CPD   = 4;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = HT * VT * CPD;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] videoXCoord;
    logic [7:0] videoYCoord;
    logic [7:0] videoData;
    logic       videoDataReady;
    logic       clearUnderrun = 1'b0;
    logic [7:0] pixelColor;
    logic       hSync;
    logic       vSync;
    logic       displayActive;
    logic       frameStart;
    logic       underrun;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Memory model: one pixel every 4 clocks, value x^y of the coordinates being requested.
    logic       memEnable  = 1'b0;
    logic       autoReady  = 1'b0;
    logic [7:0] autoData   = 8'd0;
    logic       manReady   = 1'b0;
    logic [7:0] manData    = 8'd0;
    int         memPhase   = 0;

    assign videoDataReady = memEnable ? autoReady : manReady;
    assign videoData      = memEnable ? autoData  : manData;

    video_scanout #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLOCKS_PER_DOT(CPD), .UNDERRUN_COLOR(8'hE0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .videoXCoord(videoXCoord),
        .videoYCoord(videoYCoord),
        .videoData(videoData),
        .videoDataReady(videoDataReady),
        .clearUnderrun(clearUnderrun),
        .pixelColor(pixelColor),
        .hSync(hSync),
        .vSync(vSync),
        .displayActive(displayActive),
        .frameStart(frameStart),
        .underrun(underrun)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clock);
            memPhase  = memPhase + 1;
            autoReady = (memPhase % 4 == 0);
            autoData  = videoXCoord[7:0] ^ videoYCoord;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic waitFrameStart(input int limit, output int e0);
        int n;
        n = 0;
        while (frameStart !== 1'b1 && n < limit) begin
            @(negedge clock);
            n++;
        end
        check("frameStart seen", frameStart, 1);
        e0 = cyc;
    endtask

    task automatic pulseClear(input int target);
        waitUntil(target - 1);
        clearUnderrun = 1'b1;
        @(negedge clock);
        clearUnderrun = 1'b0;
    endtask

    task automatic pulseReady(input int target, input logic [7:0] data);
        waitUntil(target - 1);
        manReady = 1'b1;
        manData  = data;
        @(negedge clock);
        manReady = 1'b0;
    endtask

    int rel, e1, e2, e3, fl;
    int hLow, vLow, actHigh;
    int dot, h, v;
    logic act;
    logic [7:0] pix;

    initial begin
        memEnable = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (50) @(negedge clock);

        // Asynchronous reset partway through line 0
        #2 reset = 1'b0;
        #1;
        check("reset pixelColor",    pixelColor, 8'h00);
        check("reset hSync",         hSync, 1);
        check("reset vSync",         vSync, 1);
        check("reset displayActive", displayActive, 0);
        check("reset frameStart",    frameStart, 0);
        check("reset underrun",      underrun, 0);
        check("reset videoXCoord",   videoXCoord, 9'd0);
        check("reset videoYCoord",   videoYCoord, 8'd0);
        repeat (2) @(negedge clock);
        check("reset held displayActive", displayActive, 0);

        // Divider starts at 0, so the first dot tick is the 4th edge after release.
        reset = 1'b1;
        rel = cyc;
        for (int i = 1; i <= CPD; i++) begin
            @(negedge clock);
            check("first frameStart timing", frameStart, (i == CPD));
            check("hSync after release", hSync, 1);
        end
        check("first dot active", displayActive, 1);
        e1 = cyc;

        pulseClear(e1 + CPD * (9 * HT));
        waitFrameStart(FRAME + 10, e2);
        check("frame period", e2 - e1, FRAME);

        // Frame 2: every clock against a time-based raster model.
        hLow = 0; vLow = 0; actHigh = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clock);
            dot = k / CPD;
            h   = dot % HT;
            v   = dot / HT;
            act = (h < HA) && (v < VA);
            pix = act ? 8'(((h >> 1) ^ (v >> 1))) : 8'h00;
            check("displayActive", displayActive, act);
            check("hSync", hSync, !((h >= HA + HF) && (h < HA + HF + HS)));
            check("vSync", vSync, !((v >= VA + VF) && (v < VA + VF + VS)));
            check("frameStart", frameStart, (k == 0));
            check("pixelColor", pixelColor, pix);
            check("no underrun", underrun, 0);
            if (k == CPD * 15 + 2)
                check("videoXCoord saturates", videoXCoord, 9'd7);
            if (!hSync) hLow++;
            if (!vSync) vLow++;
            if (displayActive) actHigh++;
        end
        check("hSync low clocks", hLow, VT * HS * CPD);
        check("vSync low clocks", vLow, VS * HT * CPD);
        check("active clocks", actHigh, VA * HA * CPD);

        // Frame 3: memory stalls, line 1 gets no data at all.
        memEnable = 1'b0;
        waitFrameStart(20, e3);
        for (int x = 0; x < HA; x++) begin
            waitUntil(e3 + CPD * (HT + x) + 1);
            check("underrun colour", pixelColor, 8'hE0);
        end
        check("underrun set", underrun, 1);
        pulseClear(e3 + CPD * (HT + 18));
        check("underrun cleared in blank", underrun, 0);
        waitUntil(e3 + CPD * (2 * HT));
        check("underrun re-set", underrun, 1);
        pulseClear(e3 + CPD * (2 * HT + 4));
        check("set beats clear", underrun, 1);

        // Fetch behaviour around the line-2 flush
        fl = e3 + CPD * (2 * HT + HA);
        pulseReady(fl, 8'h11);
        check("flush drop X", videoXCoord, 9'd0);
        check("flush drop count", dut.fifoCount, 2'd0);
        check("flush Y", videoYCoord, 8'd1);
        pulseReady(fl + 4, 8'h22);
        check("dropNext X", videoXCoord, 9'd0);
        check("dropNext count", dut.fifoCount, 2'd0);
        pulseReady(fl + 8, 8'h33);
        check("first push X", videoXCoord, 9'd1);
        check("first push count", dut.fifoCount, 2'd1);
        pulseReady(fl + 12, 8'h44);
        check("second push X", videoXCoord, 9'd2);
        check("second push count", dut.fifoCount, 2'd2);
        for (int i = 0; i < 3; i++) begin
            pulseReady(fl + 16 + 4 * i, 8'h55);
            check("full hold X", videoXCoord, 9'd2);
            check("full hold count", dut.fifoCount, 2'd2);
        end
        for (int x = 0; x < 6; x++) begin
            waitUntil(e3 + CPD * (3 * HT + x) + 2);
            check("line 3 pixel", pixelColor, (x < 2) ? 8'h33 : (x < 4) ? 8'h44 : 8'hE0);
        end

        waitUntil(e3 + CPD * (6 * HT + HA));
        check("Y after line 6", videoYCoord, 8'd3);
        waitUntil(e3 + CPD * (7 * HT + HA));
        check("Y after last visible line", videoYCoord, 8'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/video_scanout.md
Name: video_scanout

Overview:
Display-side stage downstream of the framebuffer memory manager. Generates 640x480 VGA timing from the system clock via a dot-rate divider. Prefetches 320x240 framebuffer pixels by driving videoXCoord/videoYCoord and consuming videoData/videoDataReady. Emits each framebuffer pixel doubled horizontally and vertically, with sync, blank and underrun status.

Parameters:
H_ACTIVE, 640, visible dots per line
H_FRONT, 16, horizontal front porch dots
H_SYNC, 96, hSync pulse dots
H_BACK, 48, horizontal back porch dots
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch lines
V_SYNC, 2, vSync pulse lines
V_BACK, 33, vertical back porch lines
CLOCKS_PER_DOT, 4, system clocks per dot
UNDERRUN_COLOR, 8'hE0, colour emitted on FIFO underrun

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
videoXCoord  out  9  fetch column, 0..319
videoYCoord  out  8  fetch row, 0..239
videoData  in  8  pixel byte from memory manager
videoDataReady  in  1  one-clock pulse, videoData valid
clearUnderrun  in  1  clears underrun flag
pixelColor  out  8  dot colour, 0 in blank
hSync  out  1  active-low horizontal sync
vSync  out  1  active-low vertical sync
displayActive  out  1  high on visible dots
frameStart  out  1  one-clock pulse at dot (0,0)
underrun  out  1  sticky underrun flag

Behaviour:
- Reset (reset low, async): divider/hCount/vCount = 0; FIFO empty; dropNext = 1; videoXCoord = 0, videoYCoord = 0; pixelColor = 0; hSync = 1; vSync = 1; displayActive = 0; frameStart = 0; underrun = 0. Reset mid-frame restarts timing at (0,0).
- Divider counts 0..CLOCKS_PER_DOT-1. The "dot tick" is the clock where divider = last. All timing changes happen only on dot ticks.
- H_TOTAL = sum of H params (800). V_TOTAL = sum of V params (525). hCount wraps at H_TOTAL-1 and increments vCount. vCount wraps at V_TOTAL-1 to 0.
- Outputs are registered on the dot tick from pre-increment counts:
  - displayActive = hCount < H_ACTIVE && vCount < V_ACTIVE.
  - hSync = 0 iff H_ACTIVE+H_FRONT <= hCount < H_ACTIVE+H_FRONT+H_SYNC. vSync uses the same rule on vCount.
  - frameStart pulses for one clock on the tick where hCount = 0 and vCount = 0.
- Pixel FIFO: 2 entries.
  - Pop on dot ticks with active and hCount[0] = 0. pixelColor = popped byte, held for 2 dots.
  - Pop on an empty FIFO: pixelColor = UNDERRUN_COLOR; underrun set.
  - Blank dots: pixelColor = 0, no pop.
- Fetch, on each videoDataReady pulse:
  - If dropNext = 1: discard the data and clear dropNext.
  - Else if FIFO not full, or a pop occurs in the same clock: push videoData; videoXCoord increments, saturating at 319 (no wrap).
  - Else (FIFO full, no pop): discard the data; coordinates held, so the same pixel is refetched.
- Coordinates change only in the clock after a videoDataReady pulse or on a flush.
- Line flush, on the dot tick with hCount = H_ACTIVE (every line, including vertical blank):
  - FIFO emptied; videoXCoord = 0; dropNext = 1.
  - nextLine = vCount+1, or 0 if vCount = V_TOTAL-1. videoYCoord = nextLine>>1 if nextLine < V_ACTIVE, else 0.
  - Flush and videoDataReady in the same clock: flush wins, data dropped, dropNext = 1.
- Rates: the memory manager delivers one pixel per 4 clocks; one pop occurs per 8 clocks. Blank refills 2 entries before active, so underrun must never occur with a compliant memory manager.
- underrun: sticky. Cleared by clearUnderrun. A set in the same clock as clearUnderrun wins.

Test Plan:
- Hold reset low mid-line, release -> all outputs at reset values; first frameStart exactly 1 clock after reset release plus one divider period; hSync high.
- Free-run with CLOCKS_PER_DOT = 4 -> hSync low for 384 clocks every 3200 clocks; vSync low for 2 lines every 525 lines; displayActive high for 2560 clocks per visible line.
- Memory model returns x[7:0]^y with the 4-clock cadence -> line 0 dots 0..639 show 0,0,1,1,...; lines 2k and 2k+1 identical; lines 478/479 use y = 239; underrun stays 0.
- Suppress videoDataReady for a full visible line -> pixelColor = 8'hE0 on visible dots; underrun = 1 until clearUnderrun; clearUnderrun coincident with a new underrun leaves the flag at 1.
- Pulse videoDataReady on the flush clock, then again 4 clocks later -> both discarded; FIFO count 0; videoXCoord = 0; third pulse pushed.
- Hold FIFO full in hBlank with continuous ready pulses -> videoXCoord stays 2; no push; count stays 2.
